// File: rtl/latch_bank_ctrl.sv
// rtl/latch_bank_ctrl.sv - round-robin write-port sequencer for the D-latch register bank
module latch_bank_ctrl #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int AW        = 3,
  parameter int EN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        ld,
  output logic [(1<<AW)-1:0]   len,
  output logic                 busy
);
  localparam int NL = 1 << AW;
  localparam int PW = $clog2(NREQ);
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [AW-1:0]   cap_addr, cap_addr_n;
  logic [CW-1:0]   en_cnt, en_cnt_n;
  logic [NREQ-1:0] gnt_n, done_n, req_m;
  logic [DW-1:0]   ld_n;
  logic [NL-1:0]   len_n;
  logic            busy_n;
  logic            found;
  logic [PW-1:0]   win, cand;
  int              idx;

  // The granted requester still holds REQ during HOLD, so it is masked there.
  always_comb begin
    req_m = (state == HOLD) ? (req & ~gnt) : req;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (!found && req_m[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cap_addr_n = cap_addr;
    en_cnt_n   = en_cnt;
    gnt_n      = gnt;
    done_n     = '0;
    ld_n       = ld;
    len_n      = '0;
    case (state)
      IDLE, HOLD: begin
        if (found) begin
          state_n    = SETUP;
          gnt_n      = NREQ'(1) << win;
          ld_n       = wdata[int'(win)*DW +: DW];
          cap_addr_n = addr[int'(win)*AW +: AW];
          ptr_n      = (int'(win) == NREQ-1) ? '0 : win + PW'(1);
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      SETUP: begin
        state_n  = ENABLE;
        en_cnt_n = '0;
        len_n    = NL'(1) << cap_addr;
      end
      ENABLE: begin
        if (en_cnt == CW'(EN_CYCLES-1)) begin
          state_n = HOLD;
          done_n  = gnt;
        end else begin
          en_cnt_n = en_cnt + CW'(1);
          len_n    = len;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cap_addr <= '0;
      en_cnt   <= '0;
      gnt      <= '0;
      done     <= '0;
      ld       <= '0;
      len      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cap_addr <= cap_addr_n;
      en_cnt   <= en_cnt_n;
      gnt      <= gnt_n;
      done     <= done_n;
      ld       <= ld_n;
      len      <= len_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb/tb_latch_bank_ctrl.sv - scoreboard bench for latch_bank_ctrl
module tb_latch_bank_ctrl;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NL   = 8;

  typedef struct {
    int           idx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ-1:0]     gnt, done, gnt_b, done_b;
  logic [DW-1:0]       ld, ld_b;
  logic [NL-1:0]       len, len_b;
  logic                busy, busy_b;

  int checks = 0;
  int passed = 0;
  exp_t exp_q[$];

  latch_bank_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .EN_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .ld(ld), .len(len), .busy(busy)
  );

  latch_bank_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .EN_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt_b), .done(done_b), .ld(ld_b), .len(len_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Latch bank model for the EN_CYCLES=1 instance plus sticky invariant counters.
  logic [DW-1:0] bank [NL];
  int gnt_err = 0;
  int len_err = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) if (len[i]) bank[i] <= ld;
    if ($countones(gnt) > 1) gnt_err <= gnt_err + 1;
    if ($countones(len) > 1 || (len != 0 && (done != 0 || !busy))) len_err <= len_err + 1;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; addr = '0; wdata = '0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0)  $display("FAIL reset_gnt: got %b want 0", gnt);   else passed++;
    checks++; if (done !== 4'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (ld !== 8'h00)  $display("FAIL reset_ld: got %h want 00", ld);    else passed++;
    checks++; if (len !== 8'h00) $display("FAIL reset_len: got %b want 0", len);   else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (busy_b !== 1'b0 || len_b !== 8'h00) $display("FAIL reset_b: got busy %b len %b want 0 0", busy_b, len_b); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    exp_t e; bit got; logic [NREQ-1:0] oh;
    do_reset();
    addr[0 +: AW] = 3'd3; wdata[0 +: DW] = 8'hA5; req = 4'b0001;
    exp_q.push_back('{0, 3'd3, 8'hA5});
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) $display("FAIL single_setup_gnt: got %b want 0001", gnt); else passed++;
    checks++; if (len !== 8'h00)   $display("FAIL single_setup_len: got %b want 0", len);    else passed++;
    checks++; if (ld !== 8'hA5)    $display("FAIL single_setup_ld: got %h want a5", ld);     else passed++;
    checks++; if (busy !== 1'b1)   $display("FAIL single_setup_busy: got %b want 1", busy);  else passed++;
    @(negedge clk);
    checks++; if (len !== 8'b0000_1000) $display("FAIL single_len: got %b want 00001000", len); else passed++;
    checks++; if (ld !== 8'hA5)         $display("FAIL single_enable_ld: got %h want a5", ld);  else passed++;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (done != 0) begin
        got = 1; e = exp_q.pop_front(); oh = 4'b1 << e.idx;
        checks++; if (c != 0)        $display("FAIL single_done_time: got %0d cycles late want 0", c); else passed++;
        checks++; if (done !== oh)   $display("FAIL single_done: got %b want %b", done, oh);          else passed++;
        checks++; if (len !== 8'h00) $display("FAIL single_hold_len: got %b want 0", len);            else passed++;
        checks++; if (ld !== e.d)    $display("FAIL single_hold_ld: got %h want %h", ld, e.d);        else passed++;
        checks++; if (bank[e.a] !== e.d) $display("FAIL single_bank: got %h want %h", bank[e.a], e.d); else passed++;
        req = '0;
      end
    end
    checks++; if (!got) $display("FAIL single_timeout: got no done want done"); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 4'b0) $display("FAIL single_idle: got busy %b done %b want 0 0", busy, done); else passed++;
  endtask

  task automatic test_contention();
    exp_t e; int ndone; int gcyc[$]; logic [NREQ-1:0] prev, oh; bit idle_seen;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW] = AW'(i);
      wdata[i*DW +: DW] = DW'(i + 'h10);
    end
    for (int k = 0; k < 5; k++) exp_q.push_back('{order[k], AW'(order[k]), DW'(order[k] + 'h10)});
    req = 4'b1111; prev = '0; ndone = 0; idle_seen = 0;
    for (int c = 0; c < 40 && ndone < 5; c++) begin
      @(negedge clk);
      if (gcyc.size() > 0 && !busy) idle_seen = 1;
      if (gnt != 0 && gnt != prev) gcyc.push_back(c);
      prev = gnt;
      if (done != 0) begin
        e = exp_q.pop_front(); oh = 4'b1 << e.idx;
        checks++; if (done !== oh) $display("FAIL contention_order: got %b want %b", done, oh); else passed++;
        checks++; if (ld !== e.d)  $display("FAIL contention_ld: got %h want %h", ld, e.d);    else passed++;
        checks++; if (bank[e.a] !== e.d) $display("FAIL contention_bank: got %h want %h", bank[e.a], e.d); else passed++;
        ndone++;
        if (ndone == 5) req = '0;
      end
    end
    checks++; if (ndone != 5) $display("FAIL contention_count: got %0d want 5", ndone); else passed++;
    checks++; if (gcyc.size() != 5) $display("FAIL contention_grants: got %0d want 5", gcyc.size()); else passed++;
    for (int i = 1; i < gcyc.size(); i++) begin
      checks++; if (gcyc[i] - gcyc[i-1] != 3) $display("FAIL contention_spacing: got %0d want 3", gcyc[i] - gcyc[i-1]); else passed++;
    end
    checks++; if (idle_seen) $display("FAIL contention_gap: got idle cycle want none"); else passed++;
  endtask

  task automatic test_stretched();
    exp_t e; int setup_c, done_c, len_cnt; logic [NREQ-1:0] oh;
    do_reset();
    addr[0 +: AW] = 3'd5; wdata[0 +: DW] = 8'h3C; req = 4'b0001;
    exp_q.push_back('{0, 3'd5, 8'h3C});
    setup_c = -1; done_c = -1; len_cnt = 0;
    for (int c = 0; c < 12 && done_c < 0; c++) begin
      @(negedge clk);
      if (gnt_b != 0 && setup_c < 0) setup_c = c;
      if (len_b != 0) begin
        len_cnt++;
        checks++; if (len_b !== 8'b0010_0000) $display("FAIL stretch_len: got %b want 00100000", len_b); else passed++;
      end
      if (done_b != 0) begin
        done_c = c; e = exp_q.pop_front(); oh = 4'b1 << e.idx;
        checks++; if (done_b !== oh) $display("FAIL stretch_done: got %b want %b", done_b, oh); else passed++;
        checks++; if (ld_b !== e.d)  $display("FAIL stretch_ld: got %h want %h", ld_b, e.d);   else passed++;
        req = '0;
      end
    end
    checks++; if (setup_c != 0) $display("FAIL stretch_setup: got %0d want 0", setup_c); else passed++;
    checks++; if (len_cnt != 3) $display("FAIL stretch_len_cycles: got %0d want 3", len_cnt); else passed++;
    checks++; if (done_c - setup_c != 4) $display("FAIL stretch_done_time: got %0d want 4", done_c - setup_c); else passed++;
  endtask

  task automatic test_input_churn();
    exp_t e; bit got; logic [NREQ-1:0] oh;
    do_reset();
    addr[0 +: AW] = 3'd2; wdata[0 +: DW] = 8'h5A; req = 4'b0001;
    exp_q.push_back('{0, 3'd2, 8'h5A});
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (busy) begin
        checks++; if (ld !== 8'h5A) $display("FAIL churn_ld: got %h want 5a", ld); else passed++;
      end
      if (len != 0) begin
        checks++; if (len !== 8'b0000_0100) $display("FAIL churn_len: got %b want 00000100", len); else passed++;
        req = '0;
      end
      if (done != 0) begin
        got = 1; e = exp_q.pop_front(); oh = 4'b1 << e.idx;
        checks++; if (done !== oh) $display("FAIL churn_done: got %b want %b", done, oh); else passed++;
        checks++; if (bank[e.a] !== e.d) $display("FAIL churn_bank: got %h want %h", bank[e.a], e.d); else passed++;
      end
      wdata[0 +: DW] = DW'($urandom);
      addr[0 +: AW]  = AW'($urandom);
    end
    checks++; if (!got) $display("FAIL churn_timeout: got no done want done"); else passed++;
  endtask

  task automatic test_reset_mid_write();
    exp_t e; bit seen; bit got; logic [NREQ-1:0] oh;
    do_reset();
    addr[0 +: AW] = 3'd4; wdata[0 +: DW] = 8'h77; req = 4'b0001;
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (len != 0) seen = 1;
    end
    checks++; if (!seen) $display("FAIL rstmid_enable: got no enable want enable"); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (len !== 8'h00)  $display("FAIL rstmid_len: got %b want 0", len);   else passed++;
    checks++; if (gnt !== 4'b0)   $display("FAIL rstmid_gnt: got %b want 0", gnt);   else passed++;
    checks++; if (done !== 4'b0)  $display("FAIL rstmid_done: got %b want 0", done); else passed++;
    checks++; if (busy !== 1'b0)  $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    req = 4'b1010;
    addr[1*AW +: AW] = 3'd1; wdata[1*DW +: DW] = 8'h11;
    addr[3*AW +: AW] = 3'd7; wdata[3*DW +: DW] = 8'h33;
    @(negedge clk);
    checks++; if (done !== 4'b0) $display("FAIL rstmid_nodone: got %b want 0", done); else passed++;
    rst_n = 1'b1;
    exp_q.push_back('{1, 3'd1, 8'h11});
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) $display("FAIL rstmid_ptr: got %b want 0010", gnt); else passed++;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (done != 0) begin
        got = 1; e = exp_q.pop_front(); oh = 4'b1 << e.idx;
        checks++; if (done !== oh) $display("FAIL rstmid_after_done: got %b want %b", done, oh); else passed++;
        checks++; if (bank[e.a] !== e.d) $display("FAIL rstmid_bank: got %h want %h", bank[e.a], e.d); else passed++;
        req = '0;
      end
    end
    checks++; if (!got) $display("FAIL rstmid_timeout: got no done want done"); else passed++;
  endtask

  task automatic test_sustained();
    exp_t e; int ndone, d1, g2, idle_gap; logic [NREQ-1:0] oh;
    do_reset();
    addr[2*AW +: AW] = 3'd6; wdata[2*DW +: DW] = 8'h99; req = 4'b0100;
    exp_q.push_back('{2, 3'd6, 8'h99});
    exp_q.push_back('{2, 3'd6, 8'h99});
    ndone = 0; d1 = -1; g2 = -1; idle_gap = 0;
    for (int c = 0; c < 16 && ndone < 2; c++) begin
      @(negedge clk);
      if (ndone == 1 && !busy) idle_gap++;
      if (ndone == 1 && gnt != 0 && g2 < 0) g2 = c;
      if (done != 0) begin
        e = exp_q.pop_front(); oh = 4'b1 << e.idx;
        checks++; if (done !== oh) $display("FAIL sustain_done: got %b want %b", done, oh); else passed++;
        checks++; if (bank[e.a] !== e.d) $display("FAIL sustain_bank: got %h want %h", bank[e.a], e.d); else passed++;
        ndone++;
        if (ndone == 1) d1 = c; else req = '0;
      end
    end
    checks++; if (ndone != 2)   $display("FAIL sustain_count: got %0d want 2", ndone);      else passed++;
    checks++; if (idle_gap != 1) $display("FAIL sustain_idle: got %0d want 1", idle_gap);  else passed++;
    checks++; if (g2 - d1 != 2) $display("FAIL sustain_regrant: got %0d want 2", g2 - d1); else passed++;
  endtask

  task automatic test_invariants();
    checks++; if (gnt_err != 0) $display("FAIL inv_gnt_onehot: got %0d violations want 0", gnt_err); else passed++;
    checks++; if (len_err != 0) $display("FAIL inv_len: got %0d violations want 0", len_err);        else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_stretched();
    test_input_churn();
    test_reset_mid_write();
    test_sustained();
    test_invariants();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
